bcd_ascii_streamer: RTL

- Downstream consumer of the binary-to-decimal converter.
- Accepts one packed 10-digit BCD word (4 bits per digit, most significant digit in the top nibble) through a valid/ready handshake.
- Emits the value as a byte stream of ASCII characters, most significant digit first, with optional leading-zero suppression.
- Feeds a UART/console transmit path that needs one character per handshake.

---
 rtl/bcd_ascii_streamer.sv | 123 ++++++++++++
 1 files changed

// File: rtl/bcd_ascii_streamer.sv
// Streams a packed BCD word as ASCII characters, most significant digit first,
// optionally skipping leading zeros. Define BCD_ASCII_STREAMER_NEWLINE_EN to append a '\n' terminator.
//
// state | meaning
// IDLE  | waiting for a BCD word, in_ready high
// EMIT  | presenting digit idx_q on out_char
// TERM  | presenting the newline terminator (newline build only)
module bcd_ascii_streamer #(
   parameter int DIGITS      = 10,
   parameter bit SUPPRESS_LZ = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [4*DIGITS-1:0]   in_bcd,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [7:0]            out_char,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  out_last
);

   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_EMIT = 2'd1;
`ifdef BCD_ASCII_STREAMER_NEWLINE_EN
   localparam logic [1:0] S_TERM = 2'd2;
`endif

   logic [1:0]          state_q, state_d;
   logic [4*DIGITS-1:0] bcd_q, bcd_d;
   logic [IW-1:0]       idx_q, idx_d;
   logic [IW-1:0]       start_idx;
   logic [3:0]          cur_digit;

   // Priority encoder: the last match in the ascending loop is the highest non-zero digit.
   always_comb begin
      start_idx = '0;
      if (SUPPRESS_LZ) begin
         for (int k = 0; k < DIGITS; k++) begin
            if (in_bcd[4*k +: 4] != 4'd0) start_idx = IW'(k);
         end
      end else begin
         start_idx = IW'(DIGITS - 1);
      end
   end

   always_comb begin
      cur_digit = 4'd0;
      for (int k = 0; k < DIGITS; k++) begin
         if (idx_q == IW'(k)) cur_digit = bcd_q[4*k +: 4];
      end
   end

   always_comb begin
      in_ready  = (state_q == S_IDLE) && !rst;
      out_valid = 1'b0;
      out_last  = 1'b0;
      out_char  = 8'h00;
      if (state_q == S_EMIT) begin
         out_valid = 1'b1;
         out_char  = (cur_digit <= 4'd9) ? (8'h30 + {4'h0, cur_digit}) : 8'h3F;
`ifndef BCD_ASCII_STREAMER_NEWLINE_EN
         out_last  = (idx_q == '0);
`endif
      end
`ifdef BCD_ASCII_STREAMER_NEWLINE_EN
      if (state_q == S_TERM) begin
         out_valid = 1'b1;
         out_char  = 8'h0A;
         out_last  = 1'b1;
      end
`endif
   end

   always_comb begin
      state_d = state_q;
      bcd_d   = bcd_q;
      idx_d   = idx_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               bcd_d   = in_bcd;
               idx_d   = start_idx;
               state_d = S_EMIT;
            end
         end
         S_EMIT: begin
            if (out_ready) begin
               if (idx_q == '0) begin
`ifdef BCD_ASCII_STREAMER_NEWLINE_EN
                  state_d = S_TERM;
`else
                  state_d = S_IDLE;
`endif
               end else begin
                  idx_d = idx_q - 1'b1;
               end
            end
         end
`ifdef BCD_ASCII_STREAMER_NEWLINE_EN
         S_TERM: begin
            if (out_ready) state_d = S_IDLE;
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         bcd_q   <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         bcd_q   <= bcd_d;
         idx_q   <= idx_d;
      end
   end

endmodule
